control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit that sits directly upstream of DataPath and drives its bus-select, register-enable and memory strobes.
- Steps fetch → decode → execute T-states for a subset of the ISA: ld, st, add, sub, and, or, addi, nop, halt.
- Consumes IR opcode and memory ready; produces one-hot Moore control outputs per state.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- MEM_TIMEOUT, 15, maximum cycles to wait for Mem_ready in a memory state before faulting (1..255).

Ports:
- Clock  in  1  system clock, rising edge.
- Clear  in  1  asynchronous active-high reset.
- IR  in  32  instruction register contents; only IR[31:27] is used.
- Mem_ready  in  1  memory has completed the current Read/Write.
- PCout, Zlowout, MDRout, Cout, BAout, Rout  out  1 each  bus drivers.
- PCin, IRin, MARin, MDRin, Yin, Zin, Rin  out  1 each  register loads.
- Gra, Grb, Grc  out  1 each  register-field selects to the select/encode logic.
- IncPC  out  1  ALU computes PC+1.
- Read, Write  out  1 each  memory strobes; Read also selects Mdatain into MDR.
- ALU_op  out  4  ALU operation code.
- Run  out  1  high while executing.
- Mem_err  out  1  sticky memory-timeout fault.
- Illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Clear=1: state forced to S_RST asynchronously; all outputs 0, ALU_op=ALU_NOP, Mem_err=0, wait counter=0.
- S_RST → T0 on the first edge after Clear deasserts. Run=0 in S_RST and S_HALT, Run=1 in all other states.
- All outputs are decoded from state only (Moore). Outputs not listed for a state are 0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- T2 → T3 dispatches on the IR opcode latched at that edge.
- Opcodes: ld=00000, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01100, nop=11010, halt=11011.
- Reg-reg ops (add/sub/and/or):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, ALU_op=op, Zin.
  - T5: Zlowout, Gra, Rin → T0.
- addi:
  - T3: Grb, Rout, Yin.
  - T4: Cout, ALU_ADD, Zin.
  - T5: Zlowout, Gra, Rin → T0.
- ld:
  - T3: Grb, BAout, Yin.
  - T4: Cout, ALU_ADD, Zin.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin → T0.
- st:
  - T3–T5 as ld.
  - T6: Gra, Rout, MDRin (Read=0).
  - T7: Write → T0.
- nop: T3 → T0.
- halt: T3 → S_HALT; S_HALT holds until Clear.
- Undefined opcode: Illegal=1 for the T3 cycle only, then → T0 (treated as nop).
- Memory handshake:
  - Memory states are fetch T1, ld T6 and st T7.
  - The FSM stays in a memory state with its outputs held until it samples Mem_ready=1, then advances on that edge.
  - Mem_ready in any other state is ignored.
- Timeout:
  - The wait counter resets on entry to each memory state and increments every cycle Mem_ready=0.
  - When the counter reaches MEM_TIMEOUT with Mem_ready still 0, go to S_HALT and set Mem_err=1.
  - Mem_err is cleared only by Clear.
  - Mem_ready=1 on the same edge the counter reaches MEM_TIMEOUT counts as success (no fault).
- IR may change only in T2 (when IRin loads). The sequencer does not latch the opcode separately; it branches on IR as sampled at each edge.
- Clear mid-instruction abandons the instruction immediately; no strobe is held past Clear assertion.

Decomposition:
- Package cpu_ctrl_pkg:
  - opcode localparams;
  - ALU_op encodings: ALU_NOP=0, ADD=1, SUB=2, AND=3, OR=4;
  - state enumeration S_RST, T0–T7 variants, S_HALT.
- One sub-module, ctrl_wait_timer: the MEM_TIMEOUT counter, with start/ready inputs and an expired output.
- Next-state logic and output decode stay in control_sequencer.

Test Plan:
- Reset: Clear pulse mid-T4 of an add → all outputs 0 immediately; Run=0 in S_RST; T0 one edge after Clear falls; PCout=MARin=IncPC=Zin=1.
- add r1,r2,r3 (IR=32'h18918000), Mem_ready tied 1 → T0..T5 in 6 cycles:
  - T4 has Grc=Rout=Zin=1 and ALU_op=1;
  - T5 has Zlowout=Gra=Rin=1;
  - then T0.
- ld (IR=32'h00800005), Mem_ready low 3 cycles in T6 → Read=MDRin held exactly 4 cycles; T7 asserts MDRout, Gra, Rin.
- st (IR=32'h10800005) → T6 drives Gra, Rout, MDRin with Read=0; T7 drives Write=1 for one cycle with Mem_ready=1.
- Timeout: Mem_ready stuck 0 in fetch T1 with MEM_TIMEOUT=15 → S_HALT after 15 cycles; Mem_err=1 and Run=0 until Clear.
- Illegal opcode 11111 (IR=32'hF8000000) → Illegal=1 for one cycle, then T0. Next instruction halt (IR=32'hD8000000) → Run=0, state held for 20 cycles.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU
// operation codes, the T-state enumeration and the control-word layout.
package cpu_ctrl_pkg;

  localparam int OPW = 5;

  // Opcodes carried in IR[31:27]
  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4
  } alu_op_e;

  // T3 onward is split per instruction class so every output is a pure
  // function of state; reg-reg ops get their own T4 to carry the ALU code.
  typedef enum logic [4:0] {
    S_RST,
    S_T0,
    S_T1,
    S_T2,
    S_T3_ALU,
    S_T4_ADD,
    S_T4_SUB,
    S_T4_AND,
    S_T4_OR,
    S_T4_ADDI,
    S_T5_ALU,
    S_T3_MEM,
    S_T4_MEM,
    S_T5_MEM,
    S_T6_LD,
    S_T7_LD,
    S_T6_ST,
    S_T7_ST,
    S_T3_NOP,
    S_T3_HALT,
    S_T3_ILL,
    S_HALT
  } state_e;

  // One control word, decoded from state each cycle
  typedef struct packed {
    logic    pc_out;
    logic    zlow_out;
    logic    mdr_out;
    logic    c_out;
    logic    ba_out;
    logic    reg_out;
    logic    pc_in;
    logic    ir_in;
    logic    mar_in;
    logic    mdr_in;
    logic    y_in;
    logic    z_in;
    logic    reg_in;
    logic    gra;
    logic    grb;
    logic    grc;
    logic    inc_pc;
    logic    read;
    logic    write;
    logic    run;
    logic    illegal;
    alu_op_e alu_op;
  } ctrl_t;

  // States that wait on the memory handshake
  function automatic logic is_mem_state(state_e s);
    return (s == S_T1) || (s == S_T6_LD) || (s == S_T7_ST);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer (master) and the datapath/memory side
// (slave): IR and Mem_ready flow in, strobes and status flow out.
interface control_sequencer_if;

  logic [31:0] IR;
  logic        Mem_ready;

  logic        PCout, Zlowout, MDRout, Cout, BAout, Rout;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, Rin;
  logic        Gra, Grb, Grc;
  logic        IncPC;
  logic        Read, Write;
  logic [3:0]  ALU_op;
  logic        Run;
  logic        Mem_err;
  logic        Illegal;

  modport master (
    input  IR, Mem_ready,
    output PCout, Zlowout, MDRout, Cout, BAout, Rout,
    output PCin, IRin, MARin, MDRin, Yin, Zin, Rin,
    output Gra, Grb, Grc, IncPC, Read, Write, ALU_op,
    output Run, Mem_err, Illegal
  );

  modport slave (
    output IR, Mem_ready,
    input  PCout, Zlowout, MDRout, Cout, BAout, Rout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin, Rin,
    input  Gra, Grb, Grc, IncPC, Read, Write, ALU_op,
    input  Run, Mem_err, Illegal
  );

endinterface

// File: rtl/control_sequencer_wait_timer.sv
// Memory-wait watchdog: counts cycles spent in a memory state without
// Mem_ready and flags expiry on the cycle the count would reach the limit.
module ctrl_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Clear,
  input  logic i_start,
  input  logic i_wait,
  input  logic i_ready,
  output logic o_expired
);

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] r_count;

  // Wait counter: cleared on entry to a memory state, bumps on each stalled cycle
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values; the async reset puts the counter at a known zero.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      r_count <= '0;
    end else if (i_start) begin
      r_count <= '0;
    end else if (i_wait && !i_ready) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Ready on the same edge as the limit wins, so expiry also needs !i_ready
  assign o_expired = i_wait && !i_ready && (r_count == CNT_LAST);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the ld/st/ALU/nop/halt subset.
// Moore outputs decoded from state; memory states stall on Mem_ready with a
// timeout that parks the machine in S_HALT and raises a sticky Mem_err.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW         = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 Clock,
  input  logic                 Clear,
  control_sequencer_if.master  bus
);

  state_e          r_state;
  state_e          w_next_state;
  logic            r_mem_err;
  ctrl_t           w_ctrl;
  logic [OPW-1:0]  w_opcode;
  logic            w_expired;
  logic            w_in_mem;
  logic            w_mem_entry;
  logic            w_unused_ir;

  assign w_opcode    = bus.IR[31 -: OPW];
  assign w_unused_ir = ^bus.IR[31-OPW:0];

  assign w_in_mem    = is_mem_state(r_state);
  assign w_mem_entry = is_mem_state(w_next_state) && (w_next_state != r_state);

  ctrl_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .Clock     (Clock),
    .Clear     (Clear),
    .i_start   (w_mem_entry),
    .i_wait    (w_in_mem),
    .i_ready   (bus.Mem_ready),
    .o_expired (w_expired)
  );

  // State register; Clear drops straight into S_RST
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Sticky memory-timeout flag, cleared only by Clear
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      r_mem_err <= 1'b0;
    end else if (w_expired) begin
      r_mem_err <= 1'b1;
    end
  end

  // Next-state: sequence the T-states, dispatch on IR, stall in memory states
  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RST: w_next_state = S_T0;
      S_T0:  w_next_state = S_T1;
      S_T1: begin
        if (w_expired)          w_next_state = S_HALT;
        else if (bus.Mem_ready) w_next_state = S_T2;
      end
      S_T2: begin
        case (w_opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: w_next_state = S_T3_ALU;
          OP_LD, OP_ST:                           w_next_state = S_T3_MEM;
          OP_NOP:                                 w_next_state = S_T3_NOP;
          OP_HALT:                                w_next_state = S_T3_HALT;
          default:                                w_next_state = S_T3_ILL;
        endcase
      end
      S_T3_ALU: begin
        case (w_opcode)
          OP_ADD:  w_next_state = S_T4_ADD;
          OP_SUB:  w_next_state = S_T4_SUB;
          OP_AND:  w_next_state = S_T4_AND;
          OP_OR:   w_next_state = S_T4_OR;
          OP_ADDI: w_next_state = S_T4_ADDI;
          default: w_next_state = S_T0;
        endcase
      end
      S_T4_ADD, S_T4_SUB, S_T4_AND, S_T4_OR, S_T4_ADDI:
               w_next_state = S_T5_ALU;
      S_T5_ALU: w_next_state = S_T0;
      S_T3_MEM: w_next_state = S_T4_MEM;
      S_T4_MEM: w_next_state = S_T5_MEM;
      S_T5_MEM: w_next_state = (w_opcode == OP_ST) ? S_T6_ST : S_T6_LD;
      S_T6_LD: begin
        if (w_expired)          w_next_state = S_HALT;
        else if (bus.Mem_ready) w_next_state = S_T7_LD;
      end
      S_T7_LD:   w_next_state = S_T0;
      S_T6_ST:   w_next_state = S_T7_ST;
      S_T7_ST: begin
        if (w_expired)          w_next_state = S_HALT;
        else if (bus.Mem_ready) w_next_state = S_T0;
      end
      S_T3_NOP:  w_next_state = S_T0;
      S_T3_ILL:  w_next_state = S_T0;
      S_T3_HALT: w_next_state = S_HALT;
      S_HALT:    w_next_state = S_HALT;
      default:   w_next_state = S_RST;
    endcase
  end

  // Output decode: one control word per state, everything else held low
  always_comb begin
    w_ctrl        = '0;
    w_ctrl.alu_op = ALU_NOP;
    w_ctrl.run    = (r_state != S_RST) && (r_state != S_HALT);
    case (r_state)
      S_T0: begin
        w_ctrl.pc_out = 1'b1; w_ctrl.mar_in = 1'b1;
        w_ctrl.inc_pc = 1'b1; w_ctrl.z_in   = 1'b1;
      end
      S_T1: begin
        w_ctrl.zlow_out = 1'b1; w_ctrl.pc_in  = 1'b1;
        w_ctrl.read     = 1'b1; w_ctrl.mdr_in = 1'b1;
      end
      S_T2: begin
        w_ctrl.mdr_out = 1'b1; w_ctrl.ir_in = 1'b1;
      end
      S_T3_ALU: begin
        w_ctrl.grb = 1'b1; w_ctrl.reg_out = 1'b1; w_ctrl.y_in = 1'b1;
      end
      S_T4_ADD, S_T4_SUB, S_T4_AND, S_T4_OR: begin
        w_ctrl.grc = 1'b1; w_ctrl.reg_out = 1'b1; w_ctrl.z_in = 1'b1;
        case (r_state)
          S_T4_SUB: w_ctrl.alu_op = ALU_SUB;
          S_T4_AND: w_ctrl.alu_op = ALU_AND;
          S_T4_OR:  w_ctrl.alu_op = ALU_OR;
          default:  w_ctrl.alu_op = ALU_ADD;
        endcase
      end
      S_T4_ADDI, S_T4_MEM: begin
        w_ctrl.c_out = 1'b1; w_ctrl.z_in = 1'b1; w_ctrl.alu_op = ALU_ADD;
      end
      S_T5_ALU: begin
        w_ctrl.zlow_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.reg_in = 1'b1;
      end
      S_T3_MEM: begin
        w_ctrl.grb = 1'b1; w_ctrl.ba_out = 1'b1; w_ctrl.y_in = 1'b1;
      end
      S_T5_MEM: begin
        w_ctrl.zlow_out = 1'b1; w_ctrl.mar_in = 1'b1;
      end
      S_T6_LD: begin
        w_ctrl.read = 1'b1; w_ctrl.mdr_in = 1'b1;
      end
      S_T7_LD: begin
        w_ctrl.mdr_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.reg_in = 1'b1;
      end
      S_T6_ST: begin
        w_ctrl.gra = 1'b1; w_ctrl.reg_out = 1'b1; w_ctrl.mdr_in = 1'b1;
      end
      S_T7_ST:  w_ctrl.write   = 1'b1;
      S_T3_ILL: w_ctrl.illegal = 1'b1;
      default: ;
    endcase
  end

  assign bus.PCout   = w_ctrl.pc_out;
  assign bus.Zlowout = w_ctrl.zlow_out;
  assign bus.MDRout  = w_ctrl.mdr_out;
  assign bus.Cout    = w_ctrl.c_out;
  assign bus.BAout   = w_ctrl.ba_out;
  assign bus.Rout    = w_ctrl.reg_out;
  assign bus.PCin    = w_ctrl.pc_in;
  assign bus.IRin    = w_ctrl.ir_in;
  assign bus.MARin   = w_ctrl.mar_in;
  assign bus.MDRin   = w_ctrl.mdr_in;
  assign bus.Yin     = w_ctrl.y_in;
  assign bus.Zin     = w_ctrl.z_in;
  assign bus.Rin     = w_ctrl.reg_in;
  assign bus.Gra     = w_ctrl.gra;
  assign bus.Grb     = w_ctrl.grb;
  assign bus.Grc     = w_ctrl.grc;
  assign bus.IncPC   = w_ctrl.inc_pc;
  assign bus.Read    = w_ctrl.read;
  assign bus.Write   = w_ctrl.write;
  assign bus.ALU_op  = w_ctrl.alu_op;
  assign bus.Run     = w_ctrl.run;
  assign bus.Illegal = w_ctrl.illegal;
  assign bus.Mem_err = r_mem_err;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a plan of per-cycle stimulus and
// expected control words is built from instruction-level rules, a driver
// replays it, and a monitor pops and compares every cycle.
module tb_control_sequencer;

  localparam int MEM_TIMEOUT = 15;

  localparam logic [4:0] OPC_LD = 5'd0,  OPC_ST = 5'd2,  OPC_ADD = 5'd3;
  localparam logic [4:0] OPC_SUB = 5'd4, OPC_AND = 5'd5, OPC_OR = 5'd6;
  localparam logic [4:0] OPC_ADDI = 5'd12, OPC_NOP = 5'd26, OPC_HALT = 5'd27;

  localparam logic [31:0] M_PCOUT = 32'h1 << 0,  M_ZLOWOUT = 32'h1 << 1;
  localparam logic [31:0] M_MDROUT = 32'h1 << 2, M_COUT = 32'h1 << 3;
  localparam logic [31:0] M_BAOUT = 32'h1 << 4,  M_ROUT = 32'h1 << 5;
  localparam logic [31:0] M_PCIN = 32'h1 << 6,   M_IRIN = 32'h1 << 7;
  localparam logic [31:0] M_MARIN = 32'h1 << 8,  M_MDRIN = 32'h1 << 9;
  localparam logic [31:0] M_YIN = 32'h1 << 10,   M_ZIN = 32'h1 << 11;
  localparam logic [31:0] M_RIN = 32'h1 << 12,   M_GRA = 32'h1 << 13;
  localparam logic [31:0] M_GRB = 32'h1 << 14,   M_GRC = 32'h1 << 15;
  localparam logic [31:0] M_INCPC = 32'h1 << 16, M_READ = 32'h1 << 17;
  localparam logic [31:0] M_WRITE = 32'h1 << 18, M_RUN = 32'h1 << 19;
  localparam logic [31:0] M_MERR = 32'h1 << 20,  M_ILL = 32'h1 << 21;

  logic Clock = 1'b0;
  logic Clear;

  control_sequencer_if bus ();

  control_sequencer #(
    .OPW         (5),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%08h expected=%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_dut();
    logic [31:0] v;
    v      = '0;
    v[0]   = bus.PCout;   v[1]  = bus.Zlowout; v[2]  = bus.MDRout;
    v[3]   = bus.Cout;    v[4]  = bus.BAout;   v[5]  = bus.Rout;
    v[6]   = bus.PCin;    v[7]  = bus.IRin;    v[8]  = bus.MARin;
    v[9]   = bus.MDRin;   v[10] = bus.Yin;     v[11] = bus.Zin;
    v[12]  = bus.Rin;     v[13] = bus.Gra;     v[14] = bus.Grb;
    v[15]  = bus.Grc;     v[16] = bus.IncPC;   v[17] = bus.Read;
    v[18]  = bus.Write;   v[19] = bus.Run;     v[20] = bus.Mem_err;
    v[21]  = bus.Illegal;
    v[27:24] = bus.ALU_op;
    return v;
  endfunction

  function automatic logic [31:0] alu_field(input int code);
    return 32'(code) << 24;
  endfunction

  function automatic int alu_code(input logic [4:0] op);
    case (op)
      OPC_SUB: return 2;
      OPC_AND: return 3;
      OPC_OR:  return 4;
      default: return 1;
    endcase
  endfunction

  // Per-cycle plan; clr: 0 none, 1 hold Clear this cycle, 2 assert Clear mid-cycle
  logic [31:0] plan_ir[$];
  bit          plan_rdy[$];
  int          plan_clr[$];
  logic [31:0] plan_exp[$];
  string       plan_name[$];

  logic [31:0] sb_exp[$];
  string       sb_name[$];

  logic [31:0] m_ir = '0;
  bit          m_err = 1'b0;
  int          halt_hold = 20;

  logic [4:0]  defined_ops [9] = '{OPC_LD, OPC_ST, OPC_ADD, OPC_SUB, OPC_AND,
                                   OPC_OR, OPC_ADDI, OPC_NOP, OPC_HALT};

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input string name, input bit rdy, input logic [31:0] exp, input int clr = 0);
    plan_ir.push_back(m_ir);
    plan_rdy.push_back(rdy);
    plan_clr.push_back(clr);
    plan_exp.push_back(exp);
    plan_name.push_back(name);
  endtask

  task automatic clear_seq();
    step("CLR", rnd(), 32'h0, 1);
    m_err = 1'b0;
    step("RST", rnd(), 32'h0, 0);
  endtask

  task automatic halt_then_clear();
    for (int i = 0; i < halt_hold; i++)
      step("HALT", rnd(), m_err ? M_MERR : 32'h0);
    clear_seq();
  endtask

  // A memory step holds its outputs while Mem_ready is low; the 15th stalled cycle faults
  task automatic mem_step(input string name, input logic [31:0] mask, input int wait_cycles, output bit ok);
    int n;
    n = (wait_cycles >= MEM_TIMEOUT) ? MEM_TIMEOUT : wait_cycles;
    for (int i = 0; i < n; i++) step(name, 1'b0, mask);
    ok = (wait_cycles < MEM_TIMEOUT);
    if (ok) step(name, 1'b1, mask);
    else    m_err = 1'b1;
  endtask

  task automatic gen_instr(input logic [31:0] ir, input int w_fetch, input int w_mem, input bit abort_t4);
    logic [4:0] op;
    bit ok;
    op = ir[31:27];
    step("T0", rnd(), M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
    mem_step("T1", M_RUN | M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, w_fetch, ok);
    if (!ok) begin halt_then_clear(); return; end
    m_ir = ir;
    step("T2", rnd(), M_RUN | M_MDROUT | M_IRIN);
    case (op)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ADDI: begin
        step("T3_ALU", rnd(), M_RUN | M_GRB | M_ROUT | M_YIN);
        if (op == OPC_ADDI)
          step("T4_ADDI", rnd(), M_RUN | M_COUT | M_ZIN | alu_field(1));
        else
          step("T4_RR", rnd(), M_RUN | M_GRC | M_ROUT | M_ZIN | alu_field(alu_code(op)),
               abort_t4 ? 2 : 0);
        if (abort_t4) begin clear_seq(); return; end
        step("T5_ALU", rnd(), M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
      end
      OPC_LD, OPC_ST: begin
        step("T3_MEM", rnd(), M_RUN | M_GRB | M_BAOUT | M_YIN);
        step("T4_MEM", rnd(), M_RUN | M_COUT | M_ZIN | alu_field(1));
        step("T5_MEM", rnd(), M_RUN | M_ZLOWOUT | M_MARIN);
        if (op == OPC_LD) begin
          mem_step("T6_LD", M_RUN | M_READ | M_MDRIN, w_mem, ok);
          if (!ok) begin halt_then_clear(); return; end
          step("T7_LD", rnd(), M_RUN | M_MDROUT | M_GRA | M_RIN);
        end else begin
          step("T6_ST", rnd(), M_RUN | M_GRA | M_ROUT | M_MDRIN);
          mem_step("T7_ST", M_RUN | M_WRITE, w_mem, ok);
          if (!ok) begin halt_then_clear(); return; end
        end
      end
      OPC_NOP:  step("T3_NOP", rnd(), M_RUN);
      OPC_HALT: begin
        step("T3_HALT", rnd(), M_RUN);
        halt_then_clear();
      end
      default:  step("T3_ILL", rnd(), M_RUN | M_ILL);
    endcase
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 3)  return MEM_TIMEOUT + int'($urandom_range(0, 3));
    if (r < 8)  return MEM_TIMEOUT - 1;
    return int'($urandom_range(0, 4));
  endfunction

  task automatic build_plan();
    logic [4:0]  op;
    logic [31:0] ir;
    clear_seq();
    halt_hold = 20;
    gen_instr(32'h18918000, 0, 0, 1'b0);            // add r1,r2,r3
    gen_instr(32'h18918000, 0, 0, 1'b1);            // add abandoned by Clear in T4
    gen_instr(32'h00800005, 2, 3, 1'b0);            // ld, 3 stalled cycles in T6
    gen_instr(32'h10800005, 0, 0, 1'b0);            // st
    gen_instr(32'hF8000000, 1, 0, 1'b0);            // undefined opcode
    gen_instr(32'hD8000000, 0, 0, 1'b0);            // halt, held 20 cycles
    gen_instr(32'h18918000, MEM_TIMEOUT, 0, 1'b0);  // fetch timeout
    gen_instr(32'h18918000, MEM_TIMEOUT - 1, 0, 1'b0); // ready on the limit edge
    halt_hold = 3;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 99) < 85) op = defined_ops[$urandom_range(0, 8)];
      else                            op = 5'($urandom);
      ir = {op, 27'($urandom)};
      gen_instr(ir, pick_wait(), pick_wait(), 1'b0);
    end
  endtask

  // Driver: apply one plan record per cycle, queue its expected control word
  initial begin
    int clr;
    Clear         = 1'b1;
    bus.IR        = '0;
    bus.Mem_ready = 1'b0;
    build_plan();
    repeat (2) @(posedge Clock);
    while (plan_ir.size() > 0) begin
      @(posedge Clock);
      #1;
      bus.IR        = plan_ir.pop_front();
      bus.Mem_ready = plan_rdy.pop_front();
      clr           = plan_clr.pop_front();
      Clear         = (clr == 1);
      sb_exp.push_back(plan_exp.pop_front());
      sb_name.push_back(plan_name.pop_front());
      if (clr == 2) begin
        @(negedge Clock);
        #2;
        Clear = 1'b1;
        #1;
        check("CLR_ASYNC", pack_dut(), 32'h0);
      end
    end
    repeat (2) @(posedge Clock);
    check("SB_DRAIN", 32'(sb_exp.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: every cycle the DUT presents a control word, compare it
  initial begin
    logic [31:0] e;
    string       n;
    forever begin
      @(negedge Clock);
      if (sb_exp.size() > 0) begin
        e = sb_exp.pop_front();
        n = sb_name.pop_front();
        check(n, pack_dut(), e);
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL WATCHDOG: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
